// File: rtl/busca_instrucao_pkg.sv
// Shared widths and types for the fetch stage and the instruction memory it drives,
// kept in one place so the two blocks cannot disagree on instruction or address width.
package busca_instrucao_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int FILA_PROF      = 2;
    localparam int FILA_CW        = $clog2(FILA_PROF + 1);

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] instr;
        logic [DEF_ADDR_WIDTH-1:0] pc;
    } entrada_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Fetch-stage bundle: memory read address/data, redirect request, and the decode handshake.
interface busca_instrucao_if #(
    parameter int DATA_WIDTH = busca_instrucao_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = busca_instrucao_pkg::DEF_ADDR_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] mem_dado;
    logic                  desvio;
    logic [ADDR_WIDTH-1:0] alvo;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valida;
    logic                  pronto;

    modport master (
        output read_addr, instr, instr_pc, instr_valida,
        input  mem_dado, desvio, alvo, pronto
    );

    modport slave (
        input  read_addr, instr, instr_pc, instr_valida,
        output mem_dado, desvio, alvo, pronto
    );

endinterface

// File: rtl/fila_busca.sv
// Two-entry FIFO of fetched {instr, pc}; head is shown combinationally from slot0.
// Latency: a push is visible at the head the cycle after it is written into an empty queue.
// Backpressure: none internally; the caller's credit check guarantees no push into a full queue.
module fila_busca
    import busca_instrucao_pkg::*;
#(
    parameter int W = DEF_DATA_WIDTH + DEF_ADDR_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [W-1:0]       push_dat,
    input  logic               pop,
    input  logic               clear,
    output logic [FILA_CW-1:0] count,
    output logic [W-1:0]       head_dat
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == '0) slot0 <= push_dat;
                    else             slot1 <= push_dat;
                    count <= count + FILA_CW'(1);
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - FILA_CW'(1);
                end
                2'b11: begin
                    // With one entry the pushed word becomes the new head directly.
                    if (count == FILA_CW'(1)) begin
                        slot0 <= push_dat;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_dat = slot0;

endmodule

// File: rtl/memoria.sv
// Instruction memory: negedge write port, registered read sampled at posedge.
// Latency: one cycle from read_addr to saida. Backpressure: none, reads every cycle.
// A write on the negedge before a posedge is visible to the read taken at that posedge.
module memoria #(
    parameter int DATA_WIDTH = busca_instrucao_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = busca_instrucao_pkg::DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] saida
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(negedge clock) begin
        if (write_en) mem[write_addr] <= write_data;
    end

    always_ff @(posedge clock) begin
        saida <= mem[read_addr];
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch: owns the PC, issues reads to memoria and queues results for decode.
// Latency: 2 cycles reset-to-first-valid, 1 cycle redirect-to-valid; 1 instr/cycle sustained.
// Backpressure: pronto=0 stops issue once queue + in-flight reach 2; redirect flushes the queue.
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    busca_instrucao_if.master bus
);

    localparam int W = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] UM = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] voo_pc;
    logic                  voo;
    logic [FILA_CW-1:0]    ocup;
    logic [W-1:0]          cabeca;
    logic                  pop;
    logic                  emite;
    logic [FILA_CW:0]      pendente;

    assign pop      = bus.instr_valida && bus.pronto;
    // Entries the queue will hold once the in-flight read lands; issue only if room remains.
    assign pendente = {1'b0, ocup} + {{FILA_CW{1'b0}}, voo} - {{FILA_CW{1'b0}}, pop};
    assign emite    = bus.desvio || (pendente < (FILA_CW + 1)'(FILA_PROF));

    assign bus.read_addr    = bus.desvio ? bus.alvo : pc;
    assign bus.instr_valida = (ocup != '0);
    assign bus.instr        = cabeca[W-1:ADDR_WIDTH];
    assign bus.instr_pc     = cabeca[ADDR_WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc     <= '0;
            voo    <= 1'b0;
            voo_pc <= '0;
        end else if (bus.desvio) begin
            voo    <= 1'b1;
            voo_pc <= bus.alvo;
            pc     <= bus.alvo + UM;
        end else if (emite) begin
            voo    <= 1'b1;
            voo_pc <= pc;
            pc     <= pc + UM;
        end else begin
            voo    <= 1'b0;
        end
    end

    fila_busca #(.W(W)) u_fila (
        .clock    (clock),
        .reset    (reset),
        .push     (voo && !bus.desvio),
        .push_dat ({bus.mem_dado, voo_pc}),
        .pop      (pop && !bus.desvio),
        .clear    (bus.desvio),
        .count    (ocup),
        .head_dat (cabeca)
    );

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao driving a real memoria preloaded with mem[k]=0x10+k;
// consumed instructions are checked in order against a queue of expected {instr, pc}.
module tb_busca_instrucao;
    import busca_instrucao_pkg::*;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      mem_we = 1'b0;
    logic [DEF_ADDR_WIDTH-1:0] mem_waddr = '0;
    logic [DEF_DATA_WIDTH-1:0] mem_wdata = '0;

    int checks = 0;
    int passed = 0;
    entrada_t exp_q[$];

    always #5 clock = ~clock;

    busca_instrucao_if bi ();

    memoria u_mem (
        .clock      (clock),
        .write_en   (mem_we),
        .write_addr (mem_waddr),
        .write_data (mem_wdata),
        .read_addr  (bi.read_addr),
        .saida      (bi.mem_dado)
    );

    busca_instrucao dut (
        .clock (clock),
        .reset (reset),
        .bus   (bi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) passed++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    endtask

    task automatic sb_push(input logic [7:0] d, input logic [5:0] p);
        entrada_t e;
        e.instr = d;
        e.pc    = p;
        exp_q.push_back(e);
    endtask

    // One clock: check any handshake that completes at the coming posedge, then advance.
    task automatic step();
        entrada_t e;
        @(negedge clock);
        if (bi.instr_valida && bi.pronto) begin
            if (exp_q.size() == 0) begin
                checks++;
                $error("FAIL sb_extra: observed instr 0x%0h pc 0x%0h, required no output",
                       bi.instr, bi.instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", 32'(bi.instr), 32'(e.instr));
                chk("sb_pc", 32'(bi.instr_pc), 32'(e.pc));
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        bi.desvio = 1'b0;
        bi.alvo   = '0;
        bi.pronto = 1'b0;

        // Preload memory while the fetch stage is held in reset.
        @(posedge clock);
        #1;
        for (int k = 0; k < 64; k++) begin
            mem_we    = 1'b1;
            mem_waddr = 6'(k);
            mem_wdata = 8'(16 + k);
            @(posedge clock);
            #1;
        end
        mem_we = 1'b0;

        chk("rst_valida", 32'(bi.instr_valida), 32'd0);
        chk("rst_instr", 32'(bi.instr), 32'd0);
        chk("rst_instr_pc", 32'(bi.instr_pc), 32'd0);
        chk("rst_read_addr", 32'(bi.read_addr), 32'd0);
        bi.desvio = 1'b1;
        bi.alvo   = 6'h2A;
        #1;
        chk("rst_desvio_addr", 32'(bi.read_addr), 32'h2A);
        bi.desvio = 1'b0;
        bi.alvo   = '0;
        @(posedge clock);
        #1;

        // Reset release and first fetch, followed by backpressure on 0x11.
        reset     = 1'b0;
        bi.pronto = 1'b1;
        for (int k = 0; k < 5; k++) sb_push(8'(16 + k), 6'(k));
        chk("c0_valida", 32'(bi.instr_valida), 32'd0);
        step();
        chk("c1_valida", 32'(bi.instr_valida), 32'd0);
        step();
        chk("c2_valida", 32'(bi.instr_valida), 32'd1);
        step();
        bi.pronto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_instr", 32'(bi.instr), 32'h11);
            chk("bp_read_addr", 32'(bi.read_addr), 32'd3);
            step();
        end
        bi.pronto = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_no_gap", 32'(bi.instr_valida), 32'd1);
            step();
        end
        chk("drain_bp", 32'(exp_q.size()), 32'd0);

        // Redirect to 0x20 with a full queue; head 0x15 is popped in the redirect cycle.
        bi.pronto = 1'b0;
        step();
        chk("rd_pre_instr", 32'(bi.instr), 32'h15);
        bi.desvio = 1'b1;
        bi.alvo   = 6'h20;
        bi.pronto = 1'b1;
        sb_push(8'h15, 6'h05);
        sb_push(8'h30, 6'h20);
        sb_push(8'h31, 6'h21);
        sb_push(8'h32, 6'h22);
        #1;
        chk("rd_read_addr", 32'(bi.read_addr), 32'h20);
        step();
        bi.desvio = 1'b0;
        chk("rd_no_stale", 32'(bi.instr_valida), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rd_valida", 32'(bi.instr_valida), 32'd1);
            step();
        end
        chk("drain_rd", 32'(exp_q.size()), 32'd0);

        // Redirect to the last address: 63 then wrap to 0, 1.
        bi.desvio = 1'b1;
        bi.alvo   = 6'd63;
        sb_push(8'h33, 6'h23);
        sb_push(8'h4F, 6'd63);
        sb_push(8'h10, 6'd0);
        sb_push(8'h11, 6'd1);
        step();
        bi.desvio = 1'b0;
        chk("wrap_no_stale", 32'(bi.instr_valida), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("wrap_valida", 32'(bi.instr_valida), 32'd1);
            step();
        end
        chk("drain_wrap", 32'(exp_q.size()), 32'd0);

        // Write to mem[5] on the negedge before the posedge issuing address 5.
        bi.pronto = 1'b0;
        step();
        step();
        exp_q.delete();
        bi.desvio = 1'b1;
        bi.alvo   = 6'd5;
        mem_we    = 1'b1;
        mem_waddr = 6'd5;
        mem_wdata = 8'hAA;
        sb_push(8'hAA, 6'd5);
        sb_push(8'h16, 6'd6);
        step();
        bi.desvio = 1'b0;
        mem_we    = 1'b0;
        bi.pronto = 1'b1;
        step();
        step();
        step();
        chk("drain_wr_early", 32'(exp_q.size()), 32'd0);

        // Same write one cycle after the read: the old value is fetched.
        bi.pronto = 1'b0;
        mem_we    = 1'b1;
        mem_wdata = 8'h15;
        step();
        mem_we    = 1'b0;
        step();
        exp_q.delete();
        bi.desvio = 1'b1;
        bi.alvo   = 6'd5;
        sb_push(8'h15, 6'd5);
        sb_push(8'h16, 6'd6);
        step();
        bi.desvio = 1'b0;
        mem_we    = 1'b1;
        mem_wdata = 8'hAA;
        bi.pronto = 1'b1;
        step();
        mem_we    = 1'b0;
        step();
        step();
        chk("drain_wr_late", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-cycle with the queue full.
        bi.pronto = 1'b0;
        step();
        step();
        step();
        chk("mr_pre_valida", 32'(bi.instr_valida), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("mr_valida", 32'(bi.instr_valida), 32'd0);
        chk("mr_instr", 32'(bi.instr), 32'd0);
        chk("mr_instr_pc", 32'(bi.instr_pc), 32'd0);
        chk("mr_read_addr", 32'(bi.read_addr), 32'd0);
        step();
        chk("mr_hold_valida", 32'(bi.instr_valida), 32'd0);
        reset     = 1'b0;
        bi.pronto = 1'b1;
        exp_q.delete();
        sb_push(8'h10, 6'd0);
        sb_push(8'h11, 6'd1);
        sb_push(8'h12, 6'd2);
        chk("mr_c0_valida", 32'(bi.instr_valida), 32'd0);
        step();
        chk("mr_c1_valida", 32'(bi.instr_valida), 32'd0);
        step();
        step();
        step();
        step();
        chk("drain_mr", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction fetch stage directly upstream of `memoria`. Owns the program counter and drives `memoria.read_addr`. Captures `memoria.saida` one cycle later into a 2-entry output queue, then hands instructions to decode with a valid/ready handshake. Branch redirects flush all fetched-but-unconsumed instructions.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: instruction width; matches `memoria`.
- `ADDR_WIDTH`, default 6: PC and address width; matches `memoria`.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high.
- `read_addr`  out  ADDR_WIDTH  to `memoria.read_addr`; combinational.
- `mem_dado`  in  DATA_WIDTH  from `memoria.saida`.
- `desvio`  in  1  redirect request, sampled at posedge.
- `alvo`  in  ADDR_WIDTH  redirect target; valid when `desvio`=1.
- `instr`  out  DATA_WIDTH  head-of-queue instruction.
- `instr_pc`  out  ADDR_WIDTH  address of `instr`.
- `instr_valida`  out  1  queue non-empty.
- `pronto`  in  1  decode accepts; pop when `instr_valida && pronto`.

## Operation
- State:
  - `pc`, the next address to issue.
  - `voo` (read in flight) and `voo_pc`.
  - Queue `ocup` in 0..2, entries {instr, pc}.
- `pop` = `instr_valida && pronto`.
- `read_addr` = `desvio ? alvo : pc`. `memoria` samples it every posedge; the result is kept only if issued.
- Issue condition: `emite` = `desvio || (ocup + voo - pop) < 2`. This credit rule guarantees a push never meets a full queue.
- Normal posedge:
  - if `voo`: push {`mem_dado`, `voo_pc`}.
  - if `pop`: drop head.
  - if `emite`: `voo`<=1, `voo_pc`<=`pc`, `pc`<=`pc+1`; else `voo`<=0.
- Redirect posedge (`desvio`=1):
  - Queue cleared; the in-flight result is discarded.
  - A `pop` in the same cycle still counts as consumed.
  - `voo`<=1, `voo_pc`<=`alvo`, `pc`<=`alvo+1`.
  - `desvio` takes priority over every other event.
- PC arithmetic is modulo 2^ADDR_WIDTH: 2^ADDR_WIDTH-1 wraps to 0, including for `alvo+1`.
- Simultaneous push and pop with `ocup`=2 cannot occur (credit rule). With `ocup`=1, push+pop leaves `ocup`=1 and the new head is the pushed entry.
- Self-modifying code: `memoria` writes on negedge. A read at posedge P sees a write made on the negedge before P. Instructions already in flight or queued are not refreshed.

## Timing
- Reset values (asynchronous, held while `reset`=1): `pc`=0, `voo`=0, `ocup`=0, `instr`=0, `instr_pc`=0, `instr_valida`=0.
- `read_addr` = 0 during reset, unless `desvio`=1.
- Reset asserted mid-operation discards everything immediately; no partial state survives.
- First posedge after reset release issues address 0. Address 0 enters the queue at the second posedge, so `instr_valida` rises 2 cycles after release.
- Redirect penalty: `desvio` at posedge E. `instr`=mem[`alvo`] with `instr_valida`=1 is presented from posedge E+1.
- Throughput: one instruction per cycle while `pronto`=1.
- `pronto`=0 for ≥2 cycles: the queue fills to 2, issue stops, and `read_addr` holds `pc`.

## Structure
- Shared package holds:
  - default `DATA_WIDTH`/`ADDR_WIDTH`, shared with `memoria` so the widths cannot diverge;
  - `FILA_PROF`=2.
- One sub-module: `fila_busca`, the 2-entry synchronous FIFO with push/pop/clear, count, head outputs and asynchronous reset.
- `busca_instrucao` keeps the PC, in-flight tracking, credit check and redirect muxing.

## Test plan
Bench instantiates `busca_instrucao` with a real `memoria`, preloaded mem[k]=0x10+k.

- **Reset and first fetch:** release reset, `pronto`=1.
  - Cycles 0-1: `instr_valida`=0.
  - Then `instr`/`instr_pc` = 0x10/0, 0x11/1, 0x12/2 on consecutive cycles.
- **Backpressure:** `pronto`=0 from the cycle 0x11 is presented, for 5 cycles.
  - `instr` holds 0x11; `read_addr` freezes at 3.
  - On release: 0x11, 0x12, 0x13, 0x14 on consecutive cycles, no gaps, no duplicates.
- **Redirect:** `desvio`=1, `alvo`=0x20 while the queue holds 2 entries.
  - Next cycle: `instr`=0x30, `instr_pc`=0x20, then 0x31/0x21.
  - No stale entry is ever presented.
- **Wrap:** redirect to 63.
  - Sequence is 63 (mem=0x4F), then 0 (0x10), then 1.
- **Write/read ordering:**
  - Write mem[5]=0xAA on the negedge just before the posedge that issues address 5 → `instr`=0xAA.
  - Same write one cycle later than that → `instr`=0x15.
- **Reset mid-run:** assert `reset` asynchronously mid-cycle with `ocup`=2.
  - `instr_valida`, `instr`, `instr_pc` go to 0 without waiting for a clock edge.
  - Refetch restarts at address 0.
